// File: rtl/cgra_pkg.sv
// rtl/cgra_pkg.sv - shared defaults, address-field offsets and decode types for the CGRA context memory
package cgra_pkg;

  localparam int unsigned DEF_N_ROW        = 4;
  localparam int unsigned DEF_N_LINES      = 32;
  localparam int unsigned DEF_KMEM_N_REG   = 16;
  localparam int unsigned DEF_KMEM_WIDTH   = 32;
  localparam int unsigned DEF_STARVE_LIMIT = 4;

  // Bus addresses are byte addresses; the word line starts at bit 2 and the bank field sits above it.
  localparam int unsigned WORD_LSB = 2;

  function automatic int unsigned bank_lsb(input int unsigned lw);
    return lw + WORD_LSB;
  endfunction

  typedef enum logic [1:0] {
    DEC_ROW,
    DEC_KMEM,
    DEC_ERR
  } dec_e;

endpackage

// File: rtl/ctx_kmem_regfile.sv
// rtl/ctx_kmem_regfile.sv - kernel-config register file, byte-enable write, two combinational read ports
module ctx_kmem_regfile
  import cgra_pkg::*;
#(
  parameter int unsigned N_REG = DEF_KMEM_N_REG,
  parameter int unsigned WIDTH = DEF_KMEM_WIDTH,
  localparam int unsigned AW   = $clog2(N_REG)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             we_i,
  input  logic [AW-1:0]    waddr_i,
  input  logic [3:0]       be_i,
  input  logic [31:0]      wdata_i,
  input  logic [AW-1:0]    raddr_a_i,
  output logic [WIDTH-1:0] rdata_a_o,
  input  logic [AW-1:0]    raddr_b_i,
  output logic [WIDTH-1:0] rdata_b_o
);

  logic [WIDTH-1:0] r_regs [N_REG];
  logic [WIDTH-1:0] w_bmask;

  // Byte enables beyond WIDTH simply have no bits to steer.
  for (genvar g = 0; g < WIDTH; g++) begin : g_mask
    assign w_bmask[g] = be_i[g/8];
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < N_REG; i++) begin
        r_regs[i] <= '0;
      end
    end else if (we_i) begin
      r_regs[waddr_i] <= (r_regs[waddr_i] & ~w_bmask) | (wdata_i[WIDTH-1:0] & w_bmask);
    end
  end

  assign rdata_a_o = r_regs[raddr_a_i];
  assign rdata_b_o = r_regs[raddr_b_i];

endmodule

// File: rtl/ctx_mem_arb.sv
// rtl/ctx_mem_arb.sv - arbitrates bus and controller access to row banks and kernel-config registers
module ctx_mem_arb
  import cgra_pkg::*;
#(
  parameter int unsigned N_ROW        = DEF_N_ROW,
  parameter int unsigned N_LINES      = DEF_N_LINES,
  parameter int unsigned KMEM_N_REG   = DEF_KMEM_N_REG,
  parameter int unsigned KMEM_WIDTH   = DEF_KMEM_WIDTH,
  parameter int unsigned STARVE_LIMIT = DEF_STARVE_LIMIT,
  localparam int unsigned LW          = $clog2(N_LINES),
  localparam int unsigned KW          = $clog2(KMEM_N_REG)
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  cm_req_i,
  input  logic [31:0]           cm_add_i,
  input  logic                  cm_we_i,
  input  logic [3:0]            cm_be_i,
  input  logic [31:0]           cm_wdata_i,
  output logic                  cm_gnt_o,
  output logic                  cm_rvalid_o,
  output logic [31:0]           cm_rdata_o,
  output logic                  cm_err_o,
  input  logic                  ctrl_req_i,
  input  logic [LW-1:0]         ctrl_radd_i,
  output logic                  ctrl_gnt_o,
  output logic                  ctrl_rvalid_o,
  input  logic [KW-1:0]         kmem_radd_i,
  output logic [KMEM_WIDTH-1:0] kmem_rdata_o,
  input  logic [N_ROW*32-1:0]   row_rdata_i,
  output logic [N_ROW-1:0]      row_req_o,
  output logic                  row_we_o,
  output logic [LW-1:0]         row_addr_o,
  output logic                  clk_mem_en_o
);

  localparam int unsigned   BW         = $clog2(N_ROW + 1);
  localparam int unsigned   BANK_LSB   = bank_lsb(LW);
  localparam logic [BW-1:0] KMEM_BANK  = BW'(N_ROW);
  localparam logic [7:0]    STARVE_MAX = 8'(STARVE_LIMIT);

  logic [LW-1:0]         w_line;
  logic [BW-1:0]         w_bank;
  dec_e                  w_dec;
  logic                  w_ctrl_gnt;
  logic                  w_cm_gnt;
  logic                  w_kmem_we;
  logic [KMEM_WIDTH-1:0] w_kmem_bus_rdata;
  logic                  w_unused;

  logic [7:0]            r_starve;
  logic                  r_cm_rvalid;
  logic                  r_cm_err;
  logic                  r_rd_row;
  logic [BW-1:0]         r_rd_bank;
  logic [31:0]           r_rdata;
  logic                  r_ctrl_rvalid;

  assign w_line   = cm_add_i[WORD_LSB +: LW];
  assign w_bank   = cm_add_i[BANK_LSB +: BW];
  assign w_unused = ^{cm_add_i[31:BANK_LSB+BW], cm_add_i[WORD_LSB-1:0]};

  always_comb begin
    w_dec = DEC_ERR;
    if (w_bank < KMEM_BANK) begin
      w_dec = DEC_ROW;
    end else if (w_bank == KMEM_BANK && 32'(w_line) < KMEM_N_REG) begin
      w_dec = DEC_KMEM;
    end
  end

  // Bus has priority until the controller has waited STARVE_LIMIT cycles in a row.
  assign w_ctrl_gnt = ctrl_req_i && (!cm_req_i || r_starve == STARVE_MAX);
  assign w_cm_gnt   = cm_req_i && !w_ctrl_gnt;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_starve <= '0;
    end else if (!ctrl_req_i || w_ctrl_gnt) begin
      r_starve <= '0;
    end else if (r_starve != STARVE_MAX) begin
      r_starve <= r_starve + 8'd1;
    end
  end

  always_comb begin
    row_req_o  = '0;
    row_we_o   = 1'b0;
    row_addr_o = '0;
    if (w_ctrl_gnt) begin
      row_req_o  = '1;
      row_addr_o = ctrl_radd_i;
    end else if (w_cm_gnt && w_dec == DEC_ROW) begin
      for (int b = 0; b < N_ROW; b++) begin
        if (w_bank == BW'(b)) row_req_o[b] = 1'b1;
      end
      row_we_o   = cm_we_i;
      row_addr_o = w_line;
    end
  end

  assign w_kmem_we = w_cm_gnt && w_dec == DEC_KMEM && cm_we_i;

  ctx_kmem_regfile #(
    .N_REG (KMEM_N_REG),
    .WIDTH (KMEM_WIDTH)
  ) u_kmem (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .we_i      (w_kmem_we),
    .waddr_i   (w_line[KW-1:0]),
    .be_i      (cm_be_i),
    .wdata_i   (cm_wdata_i),
    .raddr_a_i (kmem_radd_i),
    .rdata_a_o (kmem_rdata_o),
    .raddr_b_i (w_line[KW-1:0]),
    .rdata_b_o (w_kmem_bus_rdata)
  );

  // Row data arrives a cycle after the strobe, so only the bank is registered; kernel data is captured at grant.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_cm_rvalid   <= 1'b0;
      r_cm_err      <= 1'b0;
      r_rd_row      <= 1'b0;
      r_rd_bank     <= '0;
      r_rdata       <= '0;
      r_ctrl_rvalid <= 1'b0;
    end else begin
      r_cm_rvalid   <= w_cm_gnt;
      r_cm_err      <= w_cm_gnt && w_dec == DEC_ERR;
      r_rd_row      <= w_cm_gnt && w_dec == DEC_ROW && !cm_we_i;
      r_rd_bank     <= w_bank;
      r_rdata       <= (w_cm_gnt && w_dec == DEC_KMEM && !cm_we_i) ? 32'(w_kmem_bus_rdata) : '0;
      r_ctrl_rvalid <= w_ctrl_gnt;
    end
  end

  always_comb begin
    cm_rdata_o = r_rdata;
    if (r_rd_row) begin
      for (int b = 0; b < N_ROW; b++) begin
        if (r_rd_bank == BW'(b)) cm_rdata_o = row_rdata_i[b*32 +: 32];
      end
    end
  end

  assign cm_gnt_o      = w_cm_gnt;
  assign ctrl_gnt_o    = w_ctrl_gnt;
  assign cm_rvalid_o   = r_cm_rvalid;
  assign cm_err_o      = r_cm_err;
  assign ctrl_rvalid_o = r_ctrl_rvalid;
  assign clk_mem_en_o  = cm_req_i | ctrl_req_i;

endmodule

// File: doc/ctx_mem_arb.md
CTX_MEM_ARB -- requirements
Module: ctx_mem_arb

Interface
REQ-001 SHALL have parameter N_ROW, 4, number of instruction-memory row banks.
REQ-002 SHALL have parameter N_LINES, 32, instruction lines per row bank; LW = clog2(N_LINES).
REQ-003 SHALL have parameter KMEM_N_REG, 16, kernel-config registers; KW = clog2(KMEM_N_REG).
REQ-004 SHALL have parameter KMEM_WIDTH, 32, kernel-config register width, 1..32.
REQ-005 SHALL have parameter STARVE_LIMIT, 4, maximum consecutive cycles the controller request may be blocked, 1..255.
REQ-006 SHALL have clk_i  in  1  clock.
REQ-007 SHALL have rst_ni  in  1  reset, asynchronous, active-low.
REQ-008 SHALL have cm_req_i  in  1  bus request.
REQ-009 SHALL have cm_add_i  in  32  bus byte address; word line [LW+1:2], bank field BW = clog2(N_ROW+1) bits at [LW+BW+1:LW+2].
REQ-010 SHALL have cm_we_i  in  1  bus write enable.
REQ-011 SHALL have cm_be_i  in  4  bus byte enables.
REQ-012 SHALL have cm_wdata_i  in  32  bus write data.
REQ-013 SHALL have cm_gnt_o  out  1  bus grant.
REQ-014 SHALL have cm_rvalid_o  out  1  bus response valid.
REQ-015 SHALL have cm_rdata_o  out  32  bus read data, valid with cm_rvalid_o.
REQ-016 SHALL have cm_err_o  out  1  bus decode error, valid with cm_rvalid_o.
REQ-017 SHALL have ctrl_req_i  in  1  CGRA controller instruction-fetch request.
REQ-018 SHALL have ctrl_radd_i  in  LW  controller fetch line.
REQ-019 SHALL have ctrl_gnt_o  out  1  controller grant.
REQ-020 SHALL have ctrl_rvalid_o  out  1  controller fetch data valid.
REQ-021 SHALL have kmem_radd_i  in  KW  kernel-config read index.
REQ-022 SHALL have kmem_rdata_o  out  KMEM_WIDTH  kernel-config read data, combinational.
REQ-023 SHALL have row_rdata_i  in  N_ROW*32  per-row read data, one cycle after row request.
REQ-024 SHALL have row_req_o  out  N_ROW  per-row access strobe.
REQ-025 SHALL have row_we_o  out  1  row write enable.
REQ-026 SHALL have row_addr_o  out  LW  row line address.
REQ-027 SHALL have clk_mem_en_o  out  1  memory clock-gate enable = cm_req_i | ctrl_req_i.

Function
REQ-028 SHALL arbitrate combinationally per cycle: bus wins if both request, unless starve counter == STARVE_LIMIT, then controller wins and bus gnt=0.
REQ-029 SHALL count consecutive cycles ctrl_req_i is high and not granted; clear on ctrl grant or ctrl_req_i low; saturate at STARVE_LIMIT.
REQ-030 SHALL, on bus grant with bank b < N_ROW: row_req_o one-hot bit b, row_we_o=cm_we_i, row_addr_o=line field.
REQ-031 SHALL, on bus grant with bank == N_ROW: no row strobe; write updates register line[KW-1:0] under cm_be_i (bytes beyond KMEM_WIDTH ignored); line >= KMEM_N_REG ignored with error.
REQ-032 SHALL, on bus grant with bank > N_ROW: no access, cm_err_o=1 with the response.
REQ-033 SHALL raise cm_rvalid_o exactly one cycle after each bus grant, read or write.
REQ-034 SHALL return cm_rdata_o: row read -> row_rdata_i slice of registered bank; kernel read -> zero-extended register captured at grant; writes/errors -> 0.
REQ-035 SHALL, on controller grant: row_req_o all ones, row_we_o=0, row_addr_o=ctrl_radd_i, ctrl_gnt_o=1; ctrl_rvalid_o=1 one cycle later.
REQ-036 SHALL drive row_req_o=0, row_we_o=0, row_addr_o=0 with no grant.
REQ-037 SHALL make kernel write visible on kmem_rdata_o the cycle after grant; same-cycle read returns old value.
REQ-038 SHALL never assert cm_gnt_o and ctrl_gnt_o in the same cycle.

Reset
REQ-039 SHALL, while rst_ni low, clear cm_rvalid_o, cm_err_o, cm_rdata_o, ctrl_rvalid_o, starve counter and all kernel-config registers to 0.
REQ-040 SHALL discard a response pending at reset assertion; no rvalid after deassertion without new grant.

Structure
REQ-041 SHALL place default parameters, bank-field offsets and the decode-result enum (ROW, KMEM, ERR) in cgra_pkg.
REQ-042 SHALL implement the kernel-config register file as sub-module ctx_kmem_regfile (byte-enable write, combinational read).

Verification
REQ-043 SHALL test bus write bank 2 line 5 -> row_req_o=0100, row_addr_o=5, row_we_o=1, cm_rvalid_o next cycle, cm_err_o=0.
REQ-044 SHALL test bus write 0xAABBCCDD be=0011 to kernel reg 3 (reset 0) -> kmem_rdata_o[3]=0x0000CCDD next cycle.
REQ-045 SHALL test continuous bus requests with ctrl_req_i high, STARVE_LIMIT=4 -> ctrl_gnt_o in 5th cycle, cm_gnt_o=0 that cycle.
REQ-046 SHALL test bus read bank N_ROW+1 -> cm_rvalid_o=1, cm_err_o=1, cm_rdata_o=0, row_req_o=0.
REQ-047 SHALL test controller fetch line 7 then rst_ni pulse in rvalid cycle -> ctrl_rvalid_o=0, kernel registers read 0.
